// File: rtl/spi_slave.sv
// spi_slave: mode-0 SPI responder. Frames of DATA_W bits, MSB first, with a
// buffered TX byte, a buffered RX byte and a sticky overrun flag. The SPI pins
// are synchronised into the clock_in domain. clock_in must run at least 4x sclk.
module spi_slave #(
    parameter int   DATA_W    = 8,
    parameter logic SEL_LEVEL = 1'b1,
    parameter logic IDLE_MISO = 1'b0
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              ssn,
    output logic              miso,
    input  logic [DATA_W-1:0] datain,
    input  logic              load,
    output logic [DATA_W-1:0] dataout,
    input  logic              unload,
    output logic              rx_full,
    output logic              tx_ready,
    output logic              overrun,
    output logic              busy
);

    localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    state_t state, state_nx;

    // Synchroniser stages (_p0, _p1) and the sclk edge-detect stage (_p2).
    logic sclk_p0, sclk_p1, sclk_p2;
    logic mosi_p0, mosi_p1;
    logic ssn_p0, ssn_p1;

    logic sclk_rise, sclk_fall, sel_s;

    // Shift datapath and TX buffer.
    logic [DATA_W-1:0] rxsh, txsh, tx_buf, tx_fill;
    logic [CNT_W-1:0]  cnt;
    logic              reload_pend;

    // FSM strobes.
    logic start, rx_step, tx_step, tx_reload, complete, tx_take;

    // Pin synchronisers plus the edge-detect flop on sclk.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
            ssn_p0  <= 1'b0;
            ssn_p1  <= 1'b0;
        end else begin
            sclk_p0 <= sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            mosi_p0 <= mosi;
            mosi_p1 <= mosi_p0;
            ssn_p0  <= ssn;
            ssn_p1  <= ssn_p0;
        end
    end

    assign sclk_rise = sclk_p1 & ~sclk_p2;
    assign sclk_fall = ~sclk_p1 & sclk_p2;
    assign sel_s     = (ssn_p1 == SEL_LEVEL);

    // State register.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and per-cycle shift strobes; sclk edges only count while selected.
    always_comb begin
        state_nx  = state;
        start     = 1'b0;
        rx_step   = 1'b0;
        tx_step   = 1'b0;
        tx_reload = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sel_s) begin
                    state_nx = ST_SHIFT;
                    start    = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!sel_s) begin
                    state_nx = ST_IDLE;
                end else begin
                    rx_step = sclk_rise;
                    if (sclk_fall) begin
                        tx_reload = reload_pend;
                        tx_step   = ~reload_pend;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign complete = rx_step && (cnt == CNT_LAST);
    assign tx_take  = start | tx_reload;
    // An empty buffer sends zeros rather than repeating stale data.
    assign tx_fill  = tx_ready ? '0 : tx_buf;

    // Shift registers and bit counter; the fall after a completed byte
    // reloads txsh so back-to-back frames run without a deselect.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            rxsh        <= '0;
            txsh        <= '0;
            cnt         <= '0;
            reload_pend <= 1'b0;
        end else if (start) begin
            txsh        <= tx_fill;
            cnt         <= '0;
            reload_pend <= 1'b0;
        end else begin
            if (rx_step) begin
                rxsh <= {rxsh[DATA_W-2:0], mosi_p1};
                cnt  <= complete ? '0 : cnt + 1'b1;
                if (complete) begin
                    reload_pend <= 1'b1;
                end
            end
            if (tx_reload) begin
                txsh        <= tx_fill;
                reload_pend <= 1'b0;
            end else if (tx_step) begin
                txsh <= txsh << 1;
            end
        end
    end

    // TX buffer: a host load always wins over a same-cycle consume.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            tx_buf   <= '0;
            tx_ready <= 1'b1;
        end else if (load) begin
            tx_buf   <= datain;
            tx_ready <= 1'b0;
        end else if (tx_take) begin
            tx_ready <= 1'b1;
        end
    end

    // RX buffer: completion beats a same-cycle unload and then leaves overrun alone.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            dataout <= '0;
            rx_full <= 1'b0;
            overrun <= 1'b0;
        end else if (complete) begin
            dataout <= {rxsh[DATA_W-2:0], mosi_p1};
            rx_full <= 1'b1;
            if (!unload) begin
                overrun <= overrun | rx_full;
            end
        end else if (unload && rx_full) begin
            rx_full <= 1'b0;
            overrun <= 1'b0;
        end
    end

    assign miso = (state == ST_SHIFT) ? txsh[DATA_W-1] : IDLE_MISO;
    assign busy = (state == ST_SHIFT);

endmodule

// File: tb/tb_spi_slave.sv
// Directed testbench for spi_slave: bench acts as the mode-0 SPI master and the host.
module tb_spi_slave;

    localparam int HALF = 8;   // sclk half period in clock_in cycles

    logic       clock_in = 1'b0;
    logic       reset    = 1'b1;
    logic       sclk     = 1'b0;
    logic       mosi     = 1'b0;
    logic       ssn      = 1'b0;
    logic       miso;
    logic [7:0] datain   = 8'h00;
    logic       load     = 1'b0;
    logic [7:0] dataout;
    logic       unload   = 1'b0;
    logic       rx_full, tx_ready, overrun, busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mi;
    logic       rxf_e2, rxf_e3;

    spi_slave dut (
        .clock_in (clock_in),
        .reset    (reset),
        .sclk     (sclk),
        .mosi     (mosi),
        .ssn      (ssn),
        .miso     (miso),
        .datain   (datain),
        .load     (load),
        .dataout  (dataout),
        .unload   (unload),
        .rx_full  (rx_full),
        .tx_ready (tx_ready),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clock_in = ~clock_in;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clock_in);
        #1;
    endtask

    task automatic host_load(input logic [7:0] v);
        datain = v;
        load   = 1'b1;
        clk_wait(1);
        load   = 1'b0;
    endtask

    task automatic host_unload();
        unload = 1'b1;
        clk_wait(1);
        unload = 1'b0;
    endtask

    // Master frame: optional select, nbits mode-0 bits, optional deselect.
    // On the 8th rise, records rx_full 2 and 3 cycles later and can pulse unload
    // so it lands in the completion cycle.
    task automatic frame(input logic [7:0] mo, input int nbits, input bit do_sel,
                         input bit do_desel, input bit do_unload,
                         output logic [7:0] mi_o, output logic e2, output logic e3);
        mi_o = 8'h00;
        e2   = 1'b0;
        e3   = 1'b0;
        if (do_sel) begin
            ssn = 1'b1;
            clk_wait(HALF);
        end
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            clk_wait(HALF);
            mi_o = {mi_o[6:0], miso};
            sclk = 1'b1;
            if (i == 7) begin
                clk_wait(2);
                e2     = rx_full;
                unload = do_unload;
                clk_wait(1);
                unload = 1'b0;
                e3     = rx_full;
                clk_wait(HALF - 3);
            end else begin
                clk_wait(HALF);
            end
            sclk = 1'b0;
        end
        clk_wait(HALF);
        mosi = 1'b0;
        if (do_desel) begin
            ssn = 1'b0;
            clk_wait(HALF);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        clk_wait(3);
        check("rst_dataout", dataout, 8'h00);
        check("rst_flags", {4'h0, rx_full, tx_ready, overrun, busy}, 8'b0000_0100);
        check("rst_miso", {7'h0, miso}, 8'h00);
        reset = 1'b0;
        clk_wait(4);

        // 1: reset mid-frame after 4 bits, then a clean frame
        host_load(8'h5A);
        frame(8'hFF, 4, 1, 0, 0, mi, rxf_e2, rxf_e3);
        host_load(8'h66);
        check("t1_busy_mid", {7'h0, busy}, 8'h01);
        check("t1_txr_mid", {7'h0, tx_ready}, 8'h00);
        reset = 1'b1;
        sclk  = 1'b0;
        ssn   = 1'b0;
        clk_wait(2);
        check("t1_rst_dataout", dataout, 8'h00);
        check("t1_rst_flags", {4'h0, rx_full, tx_ready, overrun, busy}, 8'b0000_0100);
        check("t1_rst_miso", {7'h0, miso}, 8'h00);
        reset = 1'b0;
        clk_wait(4);
        frame(8'hC3, 8, 1, 1, 0, mi, rxf_e2, rxf_e3);
        check("t1_dataout", dataout, 8'hC3);
        check("t1_rx_full", {7'h0, rx_full}, 8'h01);
        check("t1_miso_zero", mi, 8'h00);
        host_unload();

        // 2: load A5, receive 3C, latency of rx_full
        host_load(8'hA5);
        check("t2_txr_loaded", {7'h0, tx_ready}, 8'h00);
        frame(8'h3C, 8, 1, 1, 0, mi, rxf_e2, rxf_e3);
        check("t2_miso", mi, 8'hA5);
        check("t2_rxf_2cyc", {7'h0, rxf_e2}, 8'h00);
        check("t2_rxf_3cyc", {7'h0, rxf_e3}, 8'h01);
        check("t2_dataout", dataout, 8'h3C);
        check("t2_txr", {7'h0, tx_ready}, 8'h01);
        check("t2_busy_idle", {7'h0, busy}, 8'h00);
        host_unload();
        check("t2_unload", {7'h0, rx_full}, 8'h00);

        // 3: back-to-back frames with mid-frame reload, overrun
        host_load(8'h81);
        ssn = 1'b1;
        clk_wait(HALF);
        host_load(8'h42);
        frame(8'h11, 8, 0, 0, 0, mi, rxf_e2, rxf_e3);
        check("t3_miso1", mi, 8'h81);
        check("t3_ovr_first", {7'h0, overrun}, 8'h00);
        frame(8'h22, 8, 0, 1, 0, mi, rxf_e2, rxf_e3);
        check("t3_miso2", mi, 8'h42);
        check("t3_dataout", dataout, 8'h22);
        check("t3_ovr", {6'h0, rx_full, overrun}, 8'h03);
        host_unload();
        check("t3_unload", {6'h0, rx_full, overrun}, 8'h00);

        // sclk activity while deselected must not start anything
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b1;
            clk_wait(HALF);
            sclk = 1'b0;
            clk_wait(HALF);
        end
        check("desel_sclk", {6'h0, rx_full, busy}, 8'h00);

        // 4: partial frame discarded, then full frame F0
        frame(8'hAB, 5, 1, 1, 0, mi, rxf_e2, rxf_e3);
        check("t4_partial_rxf", {7'h0, rx_full}, 8'h00);
        check("t4_partial_dout", dataout, 8'h22);
        frame(8'hF0, 8, 1, 1, 0, mi, rxf_e2, rxf_e3);
        check("t4_dataout", dataout, 8'hF0);
        check("t4_flags", {6'h0, rx_full, overrun}, 8'h02);
        host_unload();

        // 5: no load -> zeros; double load -> last byte wins
        frame(8'h99, 8, 1, 1, 0, mi, rxf_e2, rxf_e3);
        check("t5_miso_empty", mi, 8'h00);
        check("t5_dataout1", dataout, 8'h99);
        host_unload();
        host_load(8'h12);
        host_load(8'h34);
        check("t5_txr_loaded", {7'h0, tx_ready}, 8'h00);
        frame(8'h55, 8, 1, 1, 0, mi, rxf_e2, rxf_e3);
        check("t5_miso_ovw", mi, 8'h34);
        check("t5_dataout2", dataout, 8'h55);
        check("t5_txr_after", {7'h0, tx_ready}, 8'h01);

        // 6: unload in the completion cycle (rx_full already 1)
        frame(8'h6E, 8, 1, 1, 1, mi, rxf_e2, rxf_e3);
        check("t6a_dataout", dataout, 8'h6E);
        check("t6a_flags", {6'h0, rx_full, overrun}, 8'h02);
        frame(8'h01, 8, 1, 1, 0, mi, rxf_e2, rxf_e3);
        check("t6b_ovr_set", {6'h0, rx_full, overrun}, 8'h03);
        frame(8'h02, 8, 1, 1, 1, mi, rxf_e2, rxf_e3);
        check("t6c_dataout", dataout, 8'h02);
        check("t6c_flags", {6'h0, rx_full, overrun}, 8'h03);
        host_unload();
        check("t6_unload", {6'h0, rx_full, overrun}, 8'h00);
        host_unload();
        check("t6_unload_empty", {6'h0, rx_full, overrun}, 8'h00);
        check("t6_dout_kept", dataout, 8'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
